lcd_seq_ctrl: RTL and testbench
===============================

Name: lcd_seq_ctrl

Overview:
Sequencer that drives a HD44780-class character LCD over an 8-bit parallel bus using the 16-entry, 9-bit message ROM (rom_data[8] = RS, rom_data[7:0] = byte).
- After reset it waits out LCD power-up, issues a fixed init command list, then plays ROM entries 0x0..0xF once.
- Then idles with done=1. A start pulse replays the ROM message without re-init.
- It sits between the ROM and the LCD pins at the top level.

Parameters:
POWERUP_CYC, 2_000_000, cycles of idle bus after reset before first write (40 ms @ 50 MHz)
SETUP_CYC, 4, cycles RS/DB are stable with E low before E rises (min 1)
E_PULSE_CYC, 25, cycles E held high (min 1)
CMD_WAIT_CYC, 2_500, cycles after E falls before next write, normal byte (min 1)
CLEAR_WAIT_CYC, 100_000, cycles after E falls for clear/home commands (min 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: replay ROM message; honoured only when busy=0
rom_addr  out  4  ROM address, registered
rom_data  in  9  ROM word for rom_addr, combinational from ROM
lcd_rs  out  1  register select (0 = command, 1 = data)
lcd_rw  out  1  tied 0 (write only)
lcd_e  out  1  enable strobe
lcd_db  out  8  data bus
busy  out  1  1 while power-up, init or playback is in progress
done  out  1  1 after a complete playback; cleared when a new playback starts

Behaviour:
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, rom_addr=0, busy=1, done=0, state=PWRUP, all counters 0.
- rst asserted mid-transfer aborts immediately to the reset values, including dropping E. Power-up wait restarts from 0.
- Top FSM states:
  - PWRUP: count POWERUP_CYC, then INIT with init index 0.
  - INIT: write init list {RS=0: 0x38 function set 8-bit/2-line, 0x0E display+cursor on, 0x06 entry inc, 0x01 clear}. After index 3 completes, go to ROM with rom_addr=0.
  - ROM: write rom_data for rom_addr 0..15 in order. After addr 0xF completes: rom_addr wraps to 0, busy=0, done=1, state IDLE.
  - IDLE: start=1 -> done=0, busy=1, rom_addr=0, state ROM. Write of addr 0 begins the next cycle.
- start while busy=1 is ignored, not queued.
- Write engine sub-states per byte: SETUP, PULSE, HOLD.
  - SETUP, first cycle: latch {lcd_rs, lcd_db} from the current word (ROM word or init constant). lcd_e=0 for SETUP_CYC cycles.
  - PULSE: lcd_e=1 for exactly E_PULSE_CYC cycles. RS/DB unchanged.
  - HOLD: lcd_e=0 and RS/DB held for the wait count. Then the engine signals done for one cycle and the top FSM advances index/rom_addr.
- Long wait rule: the wait is CLEAR_WAIT_CYC when RS=0 and DB is 0x01, 0x02 or 0x03. Otherwise it is CMD_WAIT_CYC. This applies equally to ROM words.
- Per-byte period is exactly SETUP_CYC + E_PULSE_CYC + wait + 1 cycles: the +1 is the engine-done/advance cycle.
- rom_addr is stable at least one cycle before the SETUP latch. The ROM is combinational, so no extra latency.
- Counters are sized $clog2(max param + 1). No counter may wrap silently.
- An X on rom_data (ROM default arm) must never be latched. rom_addr is always 0..15.

Decomposition:
- lcd_pkg: top-state enum (PWRUP, INIT, ROM, IDLE), engine-state enum (SETUP, PULSE, HOLD), init command array (4 x 9 bits), RS bit index 8, CLEAR/HOME opcode constants.
- Sub-module lcd_write_engine:
  - Inputs: go, word[8:0].
  - Outputs: lcd_rs/lcd_e/lcd_db, wr_done.
  - Timing parameters passed through from lcd_seq_ctrl.
  - It owns the SETUP/PULSE/HOLD counters and the long-wait decode.

Test Plan:
1. Params POWERUP=10, SETUP=2, E_PULSE=3, CMD_WAIT=5, CLEAR_WAIT=20, release rst -> lcd_e stays 0 for 10 cycles; first E high carries RS=0, DB=0x38; E high exactly 3 cycles.
2. Same params, run to completion -> 20 E pulses in order: 0x38, 0x0E, 0x06, 0x01, then ROM words 0x080, 0x148 ('H'), … 0x0C0. After the 0x01 pulse the next E rises exactly 20+1+2 cycles after E fell. Then busy=0, done=1, rom_addr=0.
3. ROM word 0x08E (RS=0, addr set) -> CMD_WAIT applies. Patched ROM word 0x001 -> CLEAR_WAIT applies. Verify with a cycle count between E falling and the next E rising.
4. In IDLE, pulse start -> done falls the next cycle and 16 ROM pulses follow with no init commands; done=1 again at the end. start pulsed mid-playback -> no restart, pulse count still 16.
5. Assert rst for 1 cycle while lcd_e=1 during ROM addr 5 -> next cycle lcd_e=0, rom_addr=0, busy=1, done=0; full power-up and init repeat.
6. Assertion checks across all runs: RS/DB never change while lcd_e=1; lcd_rw always 0; no X on lcd_db while lcd_e=1.

Source files
------------

// File: rtl/lcd_seq_ctrl_pkg.sv
// lcd_seq_ctrl_pkg: shared states, init command list and wait decode for the LCD sequencer
package lcd_seq_ctrl_pkg;
  typedef enum logic [1:0] {PWRUP, INIT, ROM, IDLE} top_state_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} eng_state_t;
  localparam int RS_BIT = 8;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;
  localparam logic [3:0][8:0] INIT_CMDS = {9'h001, 9'h006, 9'h00E, 9'h038};
  function automatic logic is_long_wait(input logic [8:0] w);
    return !w[RS_BIT] && (w[7:0] == OP_CLEAR || w[7:0] == OP_HOME || w[7:0] == OP_HOME_ALT);
  endfunction
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lcd_seq_ctrl_if.sv
// lcd_seq_ctrl_if: start/status, ROM port and LCD pins of the sequencer
interface lcd_seq_ctrl_if;
  logic       start;
  logic [3:0] rom_addr;
  logic [8:0] rom_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       busy;
  logic       done;
  modport master (
    input  start, rom_data,
    output rom_addr, lcd_rs, lcd_rw, lcd_e, lcd_db, busy, done
  );
  modport slave (
    output start, rom_data,
    input  rom_addr, lcd_rs, lcd_rw, lcd_e, lcd_db, busy, done
  );
endinterface

// File: rtl/lcd_seq_ctrl_write_engine.sv
// lcd_write_engine: one LCD bus write as SETUP, E pulse, HOLD wait, then a one-cycle done
module lcd_write_engine
  import lcd_seq_ctrl_pkg::*;
#(
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2_500,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_go,
  input  logic [8:0] i_word,
  output logic       o_lcd_rs,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_db,
  output logic       o_wr_done
);
  localparam int CW = $clog2(max_of(max_of(SETUP_CYC, E_PULSE_CYC), max_of(CMD_WAIT_CYC, CLEAR_WAIT_CYC)) + 1);
  localparam logic [CW-1:0] S_END = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] P_END = CW'(E_PULSE_CYC - 1);
  localparam logic [CW-1:0] CMD_END = CW'(CMD_WAIT_CYC);
  localparam logic [CW-1:0] CLR_END = CW'(CLEAR_WAIT_CYC);
  eng_state_t    r_st, w_nxt_st;
  logic [CW-1:0] r_cnt, w_nxt_cnt, w_hold_end;
  logic          r_rs, r_e, w_latch;
  logic [7:0]    r_db;
  assign w_latch    = r_st == SETUP && r_cnt == '0 && i_go;
  assign w_hold_end = is_long_wait({r_rs, r_db}) ? CLR_END : CMD_END;
  // the word is presented straight through on the latch cycle so RS/DB settle a full SETUP_CYC before E
  assign o_lcd_rs   = w_latch ? i_word[RS_BIT] : r_rs;
  assign o_lcd_db   = w_latch ? i_word[7:0] : r_db;
  assign o_lcd_e    = r_e;
  assign o_wr_done  = r_st == HOLD && r_cnt == w_hold_end;
  always_comb begin
    w_nxt_st  = r_st;
    w_nxt_cnt = r_cnt + 1'b1;
    case (r_st)
      SETUP:
        if (r_cnt == '0 && !i_go) w_nxt_cnt = '0;
        else if (r_cnt == S_END) begin
          w_nxt_st  = PULSE;
          w_nxt_cnt = '0;
        end
      PULSE:
        if (r_cnt == P_END) begin
          w_nxt_st  = HOLD;
          w_nxt_cnt = '0;
        end
      HOLD:
        if (r_cnt == w_hold_end) begin
          w_nxt_st  = SETUP;
          w_nxt_cnt = '0;
        end
      default: begin
        w_nxt_st  = SETUP;
        w_nxt_cnt = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= SETUP;
      r_cnt <= '0;
      r_rs  <= 1'b0;
      r_db  <= '0;
      r_e   <= 1'b0;
    end else begin
      r_st  <= w_nxt_st;
      r_cnt <= w_nxt_cnt;
      r_e   <= w_nxt_st == PULSE;
      if (w_latch) begin
        r_rs <= i_word[RS_BIT];
        r_db <= i_word[7:0];
      end
    end
  end
endmodule

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: power-up wait, LCD init list, then plays the 16-word message ROM on demand
module lcd_seq_ctrl
  import lcd_seq_ctrl_pkg::*;
#(
  parameter int POWERUP_CYC    = 2_000_000,
  parameter int SETUP_CYC      = 4,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2_500,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input logic           clk,
  input logic           rst,
  lcd_seq_ctrl_if.master bus
);
  localparam int PW = $clog2(POWERUP_CYC + 1);
  localparam logic [PW-1:0] PW_END = PW'(POWERUP_CYC - 1);
  top_state_t    r_state, w_nxt_state;
  logic [PW-1:0] r_pw_cnt, w_nxt_pw_cnt;
  logic [1:0]    r_idx, w_nxt_idx;
  logic [3:0]    r_rom_addr, w_nxt_rom_addr;
  logic          r_busy, w_nxt_busy, r_done, w_nxt_done;
  logic          w_go, w_wr_done, w_lcd_rs, w_lcd_e;
  logic [7:0]    w_lcd_db;
  logic [8:0]    w_word;
  assign w_go         = r_state == INIT || r_state == ROM;
  assign w_word       = r_state == INIT ? INIT_CMDS[r_idx] : bus.rom_data;
  assign bus.rom_addr = r_rom_addr;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_rs   = w_lcd_rs;
  assign bus.lcd_e    = w_lcd_e;
  assign bus.lcd_db   = w_lcd_db;
  lcd_write_engine #(
    .SETUP_CYC     (SETUP_CYC),
    .E_PULSE_CYC   (E_PULSE_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_eng (
    .clk      (clk),
    .rst      (rst),
    .i_go     (w_go),
    .i_word   (w_word),
    .o_lcd_rs (w_lcd_rs),
    .o_lcd_e  (w_lcd_e),
    .o_lcd_db (w_lcd_db),
    .o_wr_done(w_wr_done)
  );
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_pw_cnt   = r_pw_cnt;
    w_nxt_idx      = r_idx;
    w_nxt_rom_addr = r_rom_addr;
    w_nxt_busy     = r_busy;
    w_nxt_done     = r_done;
    case (r_state)
      PWRUP:
        if (r_pw_cnt == PW_END) w_nxt_state = INIT;
        else w_nxt_pw_cnt = r_pw_cnt + 1'b1;
      INIT:
        if (w_wr_done) begin
          w_nxt_idx = r_idx + 1'b1;
          if (r_idx == 2'd3) w_nxt_state = ROM;
        end
      ROM:
        if (w_wr_done) begin
          w_nxt_rom_addr = r_rom_addr + 1'b1;
          if (r_rom_addr == 4'hF) begin
            w_nxt_state = IDLE;
            w_nxt_busy  = 1'b0;
            w_nxt_done  = 1'b1;
          end
        end
      IDLE:
        if (bus.start) begin
          w_nxt_state    = ROM;
          w_nxt_rom_addr = '0;
          w_nxt_busy     = 1'b1;
          w_nxt_done     = 1'b0;
        end
      default: w_nxt_state = PWRUP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PWRUP;
      r_pw_cnt   <= '0;
      r_idx      <= '0;
      r_rom_addr <= '0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_pw_cnt   <= w_nxt_pw_cnt;
      r_idx      <= w_nxt_idx;
      r_rom_addr <= w_nxt_rom_addr;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
    end
  end
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb_lcd_seq_ctrl: pulse-level model of the LCD sequencer checked against captured E strobes
module tb_lcd_seq_ctrl;
  localparam int PWR = 10, SU = 2, EP = 3, CMD = 5, CLR = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0, cyc = 0, done_rise = -1, e_done = 0;
  logic [8:0] rom [16];
  logic [8:0] q_word [$];
  int q_rise [$], q_fall [$];
  logic [8:0] e_word [$];
  int e_rise [$];
  lcd_seq_ctrl_if bus();
  lcd_seq_ctrl #(
    .POWERUP_CYC(PWR), .SETUP_CYC(SU), .E_PULSE_CYC(EP),
    .CMD_WAIT_CYC(CMD), .CLEAR_WAIT_CYC(CLR)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.rom_data = rom[bus.rom_addr];
  always #5 clk = ~clk;
  initial begin
    logic pe = 1'b0, pd = 1'b0;
    logic [8:0] pw = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.lcd_rw !== 1'b0) begin
        failures++;
        $display("FAIL lcd_rw cyc=%0d got=%b want=0", cyc, bus.lcd_rw);
      end
      if (bus.lcd_e === 1'b1) begin
        checks++;
        if ($isunknown(bus.lcd_db) || (pe && {bus.lcd_rs, bus.lcd_db} !== pw)) begin
          failures++;
          $display("FAIL bus_stable_e_high cyc=%0d got=%h want=%h", cyc, {bus.lcd_rs, bus.lcd_db}, pw);
        end
        if (!pe) begin
          q_word.push_back({bus.lcd_rs, bus.lcd_db});
          q_rise.push_back(cyc);
        end
      end else if (pe) q_fall.push_back(cyc);
      if (bus.done === 1'b1 && !pd) done_rise = cyc;
      pe = bus.lcd_e === 1'b1;
      pd = bus.done === 1'b1;
      pw = {bus.lcd_rs, bus.lcd_db};
    end
  end
  function automatic int wt(input logic [8:0] w);
    return (!w[8] && w[7:0] >= 8'h01 && w[7:0] <= 8'h03) ? CLR : CMD;
  endfunction
  // expected strobes: each byte occupies setup + pulse + its wait + one advance cycle
  task automatic build_model(input int first, input bit with_init);
    logic [8:0] init_l [4] = '{9'h038, 9'h00E, 9'h006, 9'h001};
    int t = first;
    e_word.delete();
    e_rise.delete();
    if (with_init) foreach (init_l[i]) e_word.push_back(init_l[i]);
    for (int i = 0; i < 16; i++) e_word.push_back(rom[i]);
    foreach (e_word[i]) begin
      e_rise.push_back(t);
      t += SU + EP + wt(e_word[i]) + 1;
    end
    e_done = t - SU;
  endtask
  task automatic clr();
    q_word.delete();
    q_rise.delete();
    q_fall.delete();
    done_rise = -1;
  endtask
  task automatic load_hello();
    logic [8:0] h [16] = '{9'h080, 9'h148, 9'h165, 9'h16C, 9'h16C, 9'h16F, 9'h120, 9'h157,
                           9'h16F, 9'h172, 9'h16C, 9'h164, 9'h121, 9'h13A, 9'h129, 9'h0C0};
    foreach (h[i]) rom[i] = h[i];
  endtask
  task automatic pulse_start(output int first);
    @(posedge clk); #2;
    clr();
    bus.start = 1'b1;
    first = cyc + 2 + SU;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout got done=%b want 1", nm, bus.done);
    end
    @(posedge clk); #2;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (bus.lcd_e !== 1'b0) begin failures++; $display("FAIL rst_lcd_e got=%b want=0", bus.lcd_e); end
    checks++; if (bus.lcd_rs !== 1'b0) begin failures++; $display("FAIL rst_lcd_rs got=%b want=0", bus.lcd_rs); end
    checks++; if (bus.lcd_db !== 8'h00) begin failures++; $display("FAIL rst_lcd_db got=%h want=00", bus.lcd_db); end
    checks++; if (bus.rom_addr !== 4'h0) begin failures++; $display("FAIL rst_rom_addr got=%h want=0", bus.rom_addr); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%b want=1", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", bus.done); end
  endtask
  task automatic test_powerup_init();
    clr();
    build_model(cyc + 1 + PWR + SU, 1'b1);
    rst = 1'b0;
    wait_done("powerup");
    checks++;
    if (q_word.size() != 20 || q_fall.size() != 20) begin
      failures++;
      $display("FAIL init_pulse_count got=%0d/%0d want=20", q_word.size(), q_fall.size());
    end
    foreach (e_word[i]) if (i < q_word.size() && i < q_fall.size()) begin
      checks++;
      if (q_word[i] !== e_word[i] || q_rise[i] != e_rise[i] || q_fall[i] != e_rise[i] + EP) begin
        failures++;
        $display("FAIL init_pulse%0d got=%h@%0d-%0d want=%h@%0d-%0d", i, q_word[i], q_rise[i], q_fall[i], e_word[i], e_rise[i], e_rise[i] + EP);
      end
    end
    checks++;
    if (q_rise.size() > 4 && q_fall.size() > 3 && q_rise[4] - q_fall[3] != 23) begin
      failures++;
      $display("FAIL clear_gap got=%0d want=23", q_rise[4] - q_fall[3]);
    end
    checks++; if (done_rise != e_done) begin failures++; $display("FAIL init_done_time got=%0d want=%0d", done_rise, e_done); end
    checks++; if (bus.busy !== 1'b0 || bus.rom_addr !== 4'h0) begin failures++; $display("FAIL init_idle got busy=%b addr=%h want 0/0", bus.busy, bus.rom_addr); end
  endtask
  task automatic test_long_wait();
    int first;
    int addr [6] = '{3, 5, 7, 9, 11, 13};
    int want [6] = '{CMD, CLR, CMD, CLR, CMD, CLR};
    rom[3] = 9'h08E; rom[5] = 9'h001; rom[7] = 9'h101;
    rom[9] = 9'h003; rom[11] = 9'h004; rom[13] = 9'h002;
    pulse_start(first);
    wait_done("long_wait");
    foreach (addr[k]) begin
      checks++;
      if (q_rise.size() <= addr[k] + 1 || q_fall.size() <= addr[k] || q_rise[addr[k] + 1] - q_fall[addr[k]] != want[k] + 1 + SU) begin
        failures++;
        $display("FAIL long_wait_addr%0d got=%0d want=%0d", addr[k],
                 (q_rise.size() > addr[k] + 1 && q_fall.size() > addr[k]) ? q_rise[addr[k] + 1] - q_fall[addr[k]] : -1, want[k] + 1 + SU);
      end
    end
  endtask
  task automatic test_replay();
    int first;
    load_hello();
    pulse_start(first);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL replay_start got done=%b busy=%b want 0/1", bus.done, bus.busy); end
    build_model(first, 1'b0);
    wait_done("replay");
    checks++; if (q_word.size() != 16) begin failures++; $display("FAIL replay_count got=%0d want=16", q_word.size()); end
    foreach (e_word[i]) if (i < q_word.size() && i < q_fall.size()) begin
      checks++;
      if (q_word[i] !== e_word[i] || q_rise[i] != e_rise[i] || q_fall[i] != e_rise[i] + EP) begin
        failures++;
        $display("FAIL replay_pulse%0d got=%h@%0d want=%h@%0d", i, q_word[i], q_rise[i], e_word[i], e_rise[i]);
      end
    end
    checks++; if (done_rise != e_done || bus.rom_addr !== 4'h0) begin failures++; $display("FAIL replay_done got=%0d addr=%h want=%0d addr=0", done_rise, bus.rom_addr, e_done); end
  endtask
  task automatic test_start_busy();
    int first;
    pulse_start(first);
    build_model(first, 1'b0);
    repeat (40) @(posedge clk);
    #2;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done("start_busy");
    checks++; if (q_word.size() != 16) begin failures++; $display("FAIL start_busy_count got=%0d want=16", q_word.size()); end
    foreach (e_word[i]) if (i < q_word.size()) begin
      checks++;
      if (q_word[i] !== e_word[i] || q_rise[i] != e_rise[i]) begin
        failures++;
        $display("FAIL start_busy_pulse%0d got=%h@%0d want=%h@%0d", i, q_word[i], q_rise[i], e_word[i], e_rise[i]);
      end
    end
  endtask
  task automatic test_random();
    int first;
    for (int it = 0; it < 3; it++) begin
      foreach (rom[i]) rom[i] = ($urandom_range(0, 3) == 0) ? 9'(($urandom_range(1, 3))) : 9'($urandom_range(0, 511));
      pulse_start(first);
      build_model(first, 1'b0);
      wait_done("random");
      checks++; if (q_word.size() != 16) begin failures++; $display("FAIL random%0d_count got=%0d want=16", it, q_word.size()); end
      foreach (e_word[i]) if (i < q_word.size() && i < q_fall.size()) begin
        checks++;
        if (q_word[i] !== e_word[i] || q_rise[i] != e_rise[i] || q_fall[i] != e_rise[i] + EP) begin
          failures++;
          $display("FAIL random%0d_pulse%0d got=%h@%0d want=%h@%0d", it, i, q_word[i], q_rise[i], e_word[i], e_rise[i]);
        end
      end
      checks++; if (done_rise != e_done) begin failures++; $display("FAIL random%0d_done got=%0d want=%0d", it, done_rise, e_done); end
    end
  endtask
  task automatic test_reset_mid();
    int first, n = 0;
    load_hello();
    pulse_start(first);
    while (!(bus.rom_addr == 4'h5 && bus.lcd_e === 1'b1) && n < 2000) begin
      @(posedge clk); #2;
      n++;
    end
    checks++; if (n >= 2000) begin failures++; $display("FAIL reset_mid_reach got addr=%h want 5 with e=1", bus.rom_addr); end
    rst = 1'b1;
    @(posedge clk); #2;
    checks++;
    if (bus.lcd_e !== 1'b0 || bus.rom_addr !== 4'h0 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.lcd_db !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_state got e=%b addr=%h busy=%b done=%b db=%h want 0/0/1/0/00", bus.lcd_e, bus.rom_addr, bus.busy, bus.done, bus.lcd_db);
    end
    clr();
    build_model(cyc + 1 + PWR + SU, 1'b1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done("reset_mid");
    checks++; if (q_word.size() != 20) begin failures++; $display("FAIL reset_mid_count got=%0d want=20", q_word.size()); end
    foreach (e_word[i]) if (i < q_word.size()) begin
      checks++;
      if (q_word[i] !== e_word[i] || q_rise[i] != e_rise[i]) begin
        failures++;
        $display("FAIL reset_mid_pulse%0d got=%h@%0d want=%h@%0d", i, q_word[i], q_rise[i], e_word[i], e_rise[i]);
      end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    load_hello();
    test_reset();
    test_powerup_init();
    test_long_wait();
    test_replay();
    test_start_busy();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
